// File: rtl/nco_poly.sv
// Time-multiplexed polyphonic NCO: per-voice phase accumulators feed one shared
// waveform / amplitude-scale / saturating-mix datapath, one voice every three cycles.
module nco_poly #(
  parameter int VOICES  = 8,
  parameter int PHASE_W = 24,
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 16,
  parameter int AMP_W   = 16,
  localparam int VW     = (VOICES > 1) ? $clog2(VOICES) : 1
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     sample_tick,
  input  logic                     cfg_we,
  input  logic [VW-1:0]            cfg_voice,
  input  logic [1:0]               cfg_field,
  input  logic [PHASE_W-1:0]       cfg_data,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic signed [DATA_W-1:0] rom_data,
  output logic signed [DATA_W-1:0] mix_out,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int ACC_W = DATA_W + $clog2(VOICES) + 1;
  localparam int PRD_W = DATA_W + AMP_W + 1;
  localparam logic signed [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_WAIT, S_MAC} state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [VW-1:0]              r_voice;
  logic [PHASE_W-1:0]         r_freq  [VOICES];
  logic [PHASE_W-1:0]         r_phase [VOICES];
  logic [AMP_W-1:0]           r_amp   [VOICES];
  logic [2:0]                 r_ctrl  [VOICES];
  logic [DATA_W:0]            r_p_hi;
  logic [1:0]                 r_shape;
  logic                       r_key;
  logic [AMP_W-1:0]           r_amp_l;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_busy;
  logic                       w_last;
  logic [DATA_W-1:0]          w_t;
  logic [DATA_W-1:0]          w_q;
  logic signed [DATA_W-1:0]   w_wave;
  logic signed [PRD_W-1:0]    w_prod_full;
  logic signed [DATA_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [DATA_W-1:0]   w_sat;

  assign w_last = (int'(r_voice) == VOICES - 1);
  assign busy   = r_busy;

  // Sweep sequencer: three cycles per voice, back to idle after the last MAC.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (sample_tick) w_state_nxt = S_ADDR;
        else             w_state_nxt = S_IDLE;
      end
      S_ADDR: w_state_nxt = S_WAIT;
      S_WAIT: w_state_nxt = S_MAC;
      S_MAC: begin
        if (w_last) w_state_nxt = S_IDLE;
        else        w_state_nxt = S_ADDR;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Wave generation from the latched phase, amplitude scaling and saturation.
  always_comb begin
    w_t    = r_p_hi[DATA_W:1];
    w_q    = r_p_hi[DATA_W-1:0];
    w_wave = '0;
    case (r_shape)
      2'd0: w_wave = rom_data;
      2'd1: w_wave = {~w_t[DATA_W-1], w_t[DATA_W-2:0]};
      2'd2: begin
        if (r_p_hi[DATA_W]) w_wave = MIN_V + DATA_W'(1);
        else                w_wave = MAX_V;
      end
      2'd3: begin
        if (r_p_hi[DATA_W]) w_wave = MAX_V - $signed(w_q);
        else                w_wave = {~w_q[DATA_W-1], w_q[DATA_W-2:0]};
      end
      default: w_wave = '0;
    endcase
    w_prod_full = w_wave * $signed({1'b0, r_amp_l});
    if (r_key) w_prod = DATA_W'(w_prod_full >>> AMP_W);
    else       w_prod = '0;
    w_sum = r_acc + {{(ACC_W-DATA_W){w_prod[DATA_W-1]}}, w_prod};
    // Any disagreement among the bits above the output sign bit means overflow.
    if (w_sum[ACC_W-1:DATA_W-1] == {(ACC_W-DATA_W+1){w_sum[ACC_W-1]}}) w_sat = w_sum[DATA_W-1:0];
    else if (w_sum[ACC_W-1])                                            w_sat = MIN_V;
    else                                                                w_sat = MAX_V;
  end

  // State, per-voice config/phase storage, datapath registers and outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state   <= S_IDLE;
      r_voice   <= '0;
      r_p_hi    <= '0;
      r_shape   <= 2'd0;
      r_key     <= 1'b0;
      r_amp_l   <= '0;
      r_acc     <= '0;
      r_busy    <= 1'b0;
      rom_addr  <= '0;
      mix_out   <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < VOICES; i++) begin
        r_freq[i]  <= '0;
        r_phase[i] <= '0;
        r_amp[i]   <= '0;
        r_ctrl[i]  <= 3'd0;
      end
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      out_valid <= 1'b0;
      if (sample_tick && (r_state != S_IDLE)) overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (sample_tick) begin
            r_acc   <= '0;
            r_voice <= '0;
          end
        end
        S_ADDR: begin
          r_p_hi           <= r_phase[r_voice][PHASE_W-1 -: DATA_W+1];
          rom_addr         <= r_phase[r_voice][PHASE_W-1 -: ADDR_W];
          r_phase[r_voice] <= r_phase[r_voice] + r_freq[r_voice];
          r_shape          <= r_ctrl[r_voice][1:0];
          r_key            <= r_ctrl[r_voice][2];
          r_amp_l          <= r_amp[r_voice];
        end
        S_WAIT: begin
          r_acc <= r_acc;
        end
        S_MAC: begin
          if (w_last) begin
            mix_out   <= w_sat;
            out_valid <= 1'b1;
          end else begin
            r_acc   <= w_sum;
            r_voice <= r_voice + VW'(1);
          end
        end
        default: r_acc <= r_acc;
      endcase
      // Config writes come last so a sync restart wins over the ADDR phase step.
      if (cfg_we && (int'(cfg_voice) < VOICES)) begin
        case (cfg_field)
          2'd0: r_freq[cfg_voice] <= cfg_data;
          2'd1: r_amp[cfg_voice]  <= cfg_data[AMP_W-1:0];
          2'd2: begin
            if (cfg_data[3] && cfg_data[2] && !r_ctrl[cfg_voice][2]) r_phase[cfg_voice] <= '0;
            r_ctrl[cfg_voice] <= cfg_data[2:0];
          end
          default: r_ctrl[cfg_voice] <= r_ctrl[cfg_voice];
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nco_poly.sv
// Self-checking bench for nco_poly: a per-sweep arithmetic reference model of the voices
// plus a registered ROM model, with directed scenarios and randomized configurations.
module tb_nco_poly;
  localparam int VOICES = 8;
  localparam int LAT    = 3 * VOICES;

  logic               Clk = 1'b0;
  logic               Reset;
  logic               sample_tick;
  logic               cfg_we;
  logic [2:0]         cfg_voice;
  logic [1:0]         cfg_field;
  logic [23:0]        cfg_data;
  logic [11:0]        rom_addr;
  logic signed [15:0] rom_data;
  logic signed [15:0] mix_out;
  logic               out_valid;
  logic               busy;
  logic               overrun;

  int checks   = 0;
  int failures = 0;
  int rom_mode = 1;

  int unsigned m_freq  [VOICES];
  int unsigned m_amp   [VOICES];
  int unsigned m_ctrl  [VOICES];
  int unsigned m_phase [VOICES];

  nco_poly dut (
    .Clk(Clk), .Reset(Reset), .sample_tick(sample_tick), .cfg_we(cfg_we),
    .cfg_voice(cfg_voice), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .mix_out(mix_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 Clk = ~Clk;

  function automatic logic signed [15:0] rom_fn(input logic [11:0] a, input int mode);
    logic [15:0] t;
    t = {a, a[11:8]} ^ 16'h9C35;
    if (mode == 0) return $signed({4'h0, a});
    return $signed(t);
  endfunction

  always @(posedge Clk) rom_data <= rom_fn(rom_addr, rom_mode);

  function automatic int model_wave(input int unsigned shape, input int unsigned p, input int romd);
    int q;
    case (shape)
      0: return romd;
      1: return int'((p >> 8) & 32'hFFFF) - 32768;
      2: return ((p >> 23) != 0) ? -32767 : 32767;
      default: begin
        q = int'((p >> 7) & 32'hFFFF);
        return ((p >> 23) != 0) ? (32767 - q) : (q - 32768);
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int v = 0; v < VOICES; v++) begin
      m_freq[v] = 0; m_amp[v] = 0; m_ctrl[v] = 0; m_phase[v] = 0;
    end
  endtask

  task automatic model_sweep(output int mix, output int addr0);
    longint acc;
    int unsigned p;
    int a;
    int w;
    acc = 0;
    addr0 = 0;
    for (int v = 0; v < VOICES; v++) begin
      p = m_phase[v];
      a = int'(p >> 12);
      if (v == 0) addr0 = a;
      m_phase[v] = (p + m_freq[v]) & 32'h00FF_FFFF;
      w = model_wave(m_ctrl[v] & 3, p, int'(rom_fn(12'(a), rom_mode)));
      if (((m_ctrl[v] >> 2) & 1) != 0) acc += (longint'(w) * longint'(m_amp[v])) >>> 16;
    end
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    mix = int'(acc);
  endtask

  task automatic cfg_write(input int v, input int f, input int unsigned d);
    @(negedge Clk);
    cfg_we = 1'b1; cfg_voice = 3'(v); cfg_field = 2'(f); cfg_data = 24'(d);
    @(negedge Clk);
    cfg_we = 1'b0;
    case (f)
      0: m_freq[v] = d & 32'h00FF_FFFF;
      1: m_amp[v]  = d & 32'hFFFF;
      2: begin
        if (((d >> 3) & 1) != 0 && ((d >> 2) & 1) != 0 && ((m_ctrl[v] >> 2) & 1) == 0) m_phase[v] = 0;
        m_ctrl[v] = d & 32'h7;
      end
      default: ;
    endcase
  endtask

  // Fires one tick (optionally a second at edge E0+tick2) and observes a 45-cycle window.
  task automatic run_sweep(input int tick2, output int lat, output int mix, output int addr0,
                           output int pulses, output logic bsy);
    lat = -1; mix = 0; addr0 = 0; pulses = 0; bsy = 1'b0;
    @(negedge Clk);
    sample_tick = 1'b1;
    for (int n = 0; n < 45; n++) begin
      @(negedge Clk);
      sample_tick = (n == tick2 - 1);
      if (n == 0) bsy = busy;
      if (n == 1) addr0 = int'(rom_addr);
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          mix = int'(mix_out);
        end
      end
    end
  endtask

  task automatic test_reset();
    int lat, mix, a0, pl, emix, ea0;
    logic bsy;
    cfg_write(0, 0, 24'h123456);
    cfg_write(0, 1, 16'hFFFF);
    cfg_write(0, 2, 4'b0101);
    model_sweep(emix, ea0);
    run_sweep(-1, lat, mix, a0, pl, bsy);
    @(negedge Clk);
    sample_tick = 1'b1;
    @(negedge Clk);
    sample_tick = 1'b0;
    repeat (8) @(negedge Clk);
    Reset = 1'b0;
    #1;
    checks++;
    if ({busy, out_valid, overrun} !== 3'b000 || mix_out !== 16'sd0 || rom_addr !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs: busy=%0b ov=%0b overrun=%0b mix=%0d addr=%0d, required all 0",
               busy, out_valid, overrun, mix_out, rom_addr);
    end
    @(negedge Clk);
    Reset = 1'b1;
    model_reset();
    pl = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clk);
      if (out_valid) pl++;
    end
    checks++;
    if (pl !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_abort: out_valid pulses=%0d busy=%0b, required 0 and 0", pl, busy);
    end
    model_sweep(emix, ea0);
    run_sweep(-1, lat, mix, a0, pl, bsy);
    checks++;
    if (a0 !== 0 || mix !== 0 || lat !== LAT) begin
      failures++;
      $display("FAIL reset_phase: addr0=%0d mix=%0d lat=%0d, required 0 0 %0d", a0, mix, lat, LAT);
    end
  endtask

  task automatic test_saw();
    int lat, mix, a0, pl, emix, ea0;
    logic bsy;
    int exp_tab[4] = '{-32768, -28672, -24576, -20480};
    cfg_write(0, 0, 24'h100000);
    cfg_write(0, 1, 16'hFFFF);
    cfg_write(0, 2, 4'b0101);
    for (int k = 0; k < 4; k++) begin
      model_sweep(emix, ea0);
      run_sweep(-1, lat, mix, a0, pl, bsy);
      checks++;
      if (mix !== emix || mix !== exp_tab[k] || lat !== LAT || pl !== 1 || bsy !== 1'b1) begin
        failures++;
        $display("FAIL saw_%0d: mix=%0d lat=%0d pulses=%0d busy=%0b, required mix=%0d lat=%0d pulses=1 busy=1",
                 k, mix, lat, pl, bsy, emix, LAT);
      end
    end
  endtask

  task automatic test_square();
    int lat, mix, a0, pl, emix, ea0;
    logic bsy;
    for (int v = 0; v < 4; v++) begin
      cfg_write(v, 0, 0);
      cfg_write(v, 1, 16'hFFFF);
      cfg_write(v, 2, 4'b0000);
      cfg_write(v, 2, 4'b1110);
    end
    model_sweep(emix, ea0);
    run_sweep(-1, lat, mix, a0, pl, bsy);
    checks++;
    if (mix !== emix || mix !== 32767) begin
      failures++;
      $display("FAIL square_pos_sat: mix=%0d, required %0d", mix, emix);
    end
    for (int v = 0; v < 4; v++) cfg_write(v, 0, 24'h800000);
    for (int k = 0; k < 2; k++) begin
      model_sweep(emix, ea0);
      run_sweep(-1, lat, mix, a0, pl, bsy);
      checks++;
      if (mix !== emix || (k == 1 && mix !== -32768)) begin
        failures++;
        $display("FAIL square_neg_%0d: mix=%0d, required %0d", k, mix, emix);
      end
    end
  endtask

  task automatic test_sine();
    int lat, mix, a0, pl, emix, ea0;
    logic bsy;
    rom_mode = 0;
    for (int v = 1; v < 4; v++) cfg_write(v, 2, 4'b0000);
    cfg_write(0, 0, 24'h001000);
    cfg_write(0, 2, 4'b0000);
    cfg_write(0, 2, 4'b1100);
    for (int k = 0; k < 3; k++) begin
      model_sweep(emix, ea0);
      run_sweep(-1, lat, mix, a0, pl, bsy);
      checks++;
      if (a0 !== ea0 || a0 !== k || mix !== emix) begin
        failures++;
        $display("FAIL sine_%0d: addr=%0d mix=%0d, required addr=%0d mix=%0d", k, a0, mix, ea0, emix);
      end
    end
    rom_mode = 1;
  endtask

  task automatic test_sync();
    int lat, mix, a0, pl, emix, ea0;
    logic bsy;
    cfg_write(0, 0, 24'h400000);
    for (int k = 0; k < 3; k++) begin
      model_sweep(emix, ea0);
      run_sweep(-1, lat, mix, a0, pl, bsy);
    end
    checks++;
    if (a0 !== ea0 || mix !== emix) begin
      failures++;
      $display("FAIL sync_pre: addr=%0d mix=%0d, required addr=%0d mix=%0d", a0, mix, ea0, emix);
    end
    cfg_write(0, 2, 4'b0000);
    cfg_write(0, 2, 4'b1100);
    model_sweep(emix, ea0);
    run_sweep(-1, lat, mix, a0, pl, bsy);
    checks++;
    if (a0 !== 0 || a0 !== ea0 || mix !== emix) begin
      failures++;
      $display("FAIL sync_restart: addr=%0d mix=%0d, required addr=0 mix=%0d", a0, mix, emix);
    end
  endtask

  task automatic test_overrun();
    int lat, mix, a0, pl, emix, ea0;
    logic bsy;
    checks++;
    if (overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_idle: overrun=%0b, required 0", overrun);
    end
    cfg_write(1, 0, 24'h0ABCDE);
    cfg_write(1, 1, 16'h8000);
    cfg_write(1, 2, 4'b0111);
    model_sweep(emix, ea0);
    run_sweep(5, lat, mix, a0, pl, bsy);
    checks++;
    if (overrun !== 1'b1 || pl !== 1 || lat !== LAT || mix !== emix) begin
      failures++;
      $display("FAIL overrun_tick: overrun=%0b pulses=%0d lat=%0d mix=%0d, required 1 1 %0d %0d",
               overrun, pl, lat, mix, LAT, emix);
    end
    model_sweep(emix, ea0);
    run_sweep(-1, lat, mix, a0, pl, bsy);
    checks++;
    if (a0 !== ea0 || mix !== emix || overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_once: addr=%0d mix=%0d overrun=%0b, required addr=%0d mix=%0d overrun=1",
               a0, mix, overrun, ea0, emix);
    end
  endtask

  task automatic test_back_to_back();
    int lat, mix, a0, pl, emix, ea0;
    logic bsy;
    model_sweep(emix, ea0);
    run_sweep(LAT, lat, mix, a0, pl, bsy);
    checks++;
    if (pl !== 1 || mix !== emix || lat !== LAT) begin
      failures++;
      $display("FAIL last_mac_tick: pulses=%0d mix=%0d lat=%0d, required 1 %0d %0d", pl, mix, lat, emix, LAT);
    end
    model_sweep(emix, ea0);
    run_sweep(-1, lat, mix, a0, pl, bsy);
    checks++;
    if (a0 !== ea0 || mix !== emix) begin
      failures++;
      $display("FAIL last_mac_follow: addr=%0d mix=%0d, required %0d %0d", a0, mix, ea0, emix);
    end
  endtask

  task automatic test_random();
    int lat, mix, a0, pl, emix, ea0;
    logic bsy;
    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < VOICES; v++) begin
        cfg_write(v, 0, $urandom & 32'h00FF_FFFF);
        cfg_write(v, 1, $urandom & 32'hFFFF);
        cfg_write(v, 2, $urandom_range(0, 15));
      end
      for (int k = 0; k < 2; k++) begin
        model_sweep(emix, ea0);
        run_sweep(-1, lat, mix, a0, pl, bsy);
        checks++;
        if (mix !== emix || a0 !== ea0 || lat !== LAT || pl !== 1) begin
          failures++;
          $display("FAIL random_%0d_%0d: mix=%0d addr=%0d lat=%0d pulses=%0d, required %0d %0d %0d 1",
                   r, k, mix, a0, lat, pl, emix, ea0, LAT);
        end
      end
    end
  endtask

  initial begin
    Reset = 1'b0; sample_tick = 1'b0; cfg_we = 1'b0;
    cfg_voice = 3'd0; cfg_field = 2'd0; cfg_data = 24'd0;
    model_reset();
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    test_reset();
    test_saw();
    test_square();
    test_sine();
    test_sync();
    test_overrun();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
